// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared types and constants for the Sobol fp16 sample collector
// Contents:
//   fp16_t            16-bit raw fp16 sample, passed through bit-exact
//   coll_state_e      collector FSM states IDLE, COLLECT, DONE
//   FP16_EXP_ONE      biased exponent of 1.0; any exponent at or above it is >= 1.0
//   fp16_out_of_unit  1 when a sample lies outside [0,1): negative sign or exponent >= FP16_EXP_ONE
package sobol_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } coll_state_e;

  localparam logic [4:0] FP16_EXP_ONE = 5'd15;

  function automatic logic fp16_out_of_unit(input fp16_t v);
    return v[15] || (v[14:10] >= FP16_EXP_ONE);
  endfunction

endpackage

// File: rtl/sobol_sync_fifo.sv
// rtl/sobol_sync_fifo.sv - first-word-fall-through synchronous FIFO for fp16 samples
// Parameters: DEPTH entries (power of two, >= 2)
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push_i        write push_data_i; honoured when not full, or when full with a pop this cycle
//   push_data_i   sample to write
//   pop_i         consume the head entry; ignored when empty
//   pop_data_o    head entry, valid whenever empty_o=0, zero when empty
//   full_o        level_o == DEPTH
//   empty_o       level_o == 0
//   level_o       occupancy, 0..DEPTH
module sobol_sync_fifo
  import sobol_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fp16_t                  push_data_i,
  input  logic                   pop_i,
  output fp16_t                  pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  fp16_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot the write lands in: wr_ptr == rd_ptr,
  // and the head is read combinationally before the edge overwrites it.
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sobol_sample_collector.sv
// rtl/sobol_sample_collector.sv - captures a commanded number of generator samples into a FIFO
// Optional feature macro: SOBOL_RANGE_CHECK_EN (adds sticky range_err output)
// Parameters: DEPTH FIFO entries (power of two, >= 2), CNT_W command/counter width
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cmd_start    pulse: begin collecting cmd_count samples (IDLE only)
//   cmd_count    samples to collect, sampled with an accepted cmd_start
//   cmd_abort    pulse: end the collection now (COLLECT only)
//   in_valid     in_data carries a new free-running generator sample
//   in_data      fp16 sample
//   out_valid    FIFO non-empty
//   out_ready    consumer takes out_data when out_valid=1
//   out_data     FIFO head, fall-through
//   busy         collecting
//   done         one-cycle completion pulse (count reached, abort, or zero-count start)
//   drop_cnt     samples lost to a full FIFO in the current collection, saturating
//   level        FIFO occupancy
//   range_err    (SOBOL_RANGE_CHECK_EN only) a stored sample was outside [0,1)
module sobol_sample_collector
  import sobol_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic [CNT_W-1:0]       cmd_count,
  input  logic                   cmd_abort,
  input  logic                   in_valid,
  input  logic [15:0]            in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] level
`ifdef SOBOL_RANGE_CHECK_EN
  ,
  output logic                   range_err
`endif
);

  coll_state_e      state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] collected_q, collected_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             zdone_q, zdone_d;
  logic             push, pop, fifo_full, fifo_empty;

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign busy      = (state_q == COLLECT);
  // A zero-count start never leaves IDLE, so its done pulse comes from a separate flag.
  assign done      = (state_q == DONE) || zdone_q;
  assign drop_cnt  = drop_q;

  sobol_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    collected_d = collected_q;
    drop_d      = drop_q;
    zdone_d     = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          drop_d = '0;
          if (cmd_count != '0) begin
            state_d     = COLLECT;
            target_d    = cmd_count;
            collected_d = '0;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cmd_abort) begin
          state_d = DONE;
        end else if (in_valid) begin
          if (!fifo_full || pop) begin
            push        = 1'b1;
            collected_d = collected_q + 1'b1;
            if (collected_d == target_q) state_d = DONE;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      collected_q <= '0;
      drop_q      <= '0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      collected_q <= collected_d;
      drop_q      <= drop_d;
      zdone_q     <= zdone_d;
    end
  end

`ifdef SOBOL_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  // Out-of-range samples are still stored; the flag only records that one was seen.
  always_comb begin
    range_err_d = range_err_q;
    if (state_q == IDLE && cmd_start)          range_err_d = 1'b0;
    else if (push && fp16_out_of_unit(in_data)) range_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`endif

endmodule
